// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN readout controller.
// Holds the FSM state encoding, the class-index width rule and saturating increment.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SCAN,
        RESULT
    } readout_state_t;

    // Class index needs at least one bit even for two classes.
    function automatic int cls_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/snn_readout_ctrl_if.sv
// Host and SNN-core facing signals of the readout controller.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// the producer keeps valid and its payload steady until that edge; spk_valid is a single-cycle strobe with no ready.
interface snn_readout_ctrl_if
    import snn_pkg::*;
#(
    parameter int N_OUT = 10,
    parameter int CNT_W = 8
);
    localparam int CLS_W = cls_w(N_OUT);

    logic             req_valid;
    logic             req_ready;
    logic             start_en;
    logic             spk_valid;
    logic [N_OUT-1:0] spk;
    logic             res_valid;
    logic             res_ready;
    logic [CLS_W-1:0] res_class;
    logic [CNT_W-1:0] res_count;
    logic             busy;

    modport slave (
        input  req_valid, spk_valid, spk, res_ready,
        output req_ready, start_en, res_valid, res_class, res_count, busy
    );

    modport master (
        output req_valid, spk_valid, spk, res_ready,
        input  req_ready, start_en, res_valid, res_class, res_count, busy
    );

endinterface

// File: rtl/spike_counter_bank.sv
// Per-class saturating spike counters with a flat view and an indexed read port.
module spike_counter_bank
    import snn_pkg::*;
#(
    parameter int N_OUT = 10,
    parameter int CNT_W = 8,
    parameter int CLS_W = cls_w(N_OUT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   en,
    input  logic [N_OUT-1:0]       spk,
    input  logic [CLS_W-1:0]       rd_idx,
    output logic [N_OUT*CNT_W-1:0] cnt_flat,
    output logic [CNT_W-1:0]       rd_cnt
);
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic [CNT_W-1:0] cnt [N_OUT];

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (spk[i]) cnt[i] <= CNT_W'(sat_inc(32'(cnt[i]), CNT_MAX));
            end
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < N_OUT; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
    end

    // Compare-based mux keeps out-of-range indices harmless when N_OUT is not a power of two.
    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (rd_idx == CLS_W'(i)) rd_cnt = cnt[i];
        end
    end

endmodule

// File: rtl/snn_readout_ctrl.sv
// Runs the SNN core for T_STEPS timesteps, counts output spikes per class,
// then scans the counts one class per cycle and returns the argmax.
module snn_readout_ctrl
    import snn_pkg::*;
#(
    parameter int N_OUT   = 10,
    parameter int T_STEPS = 100,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    snn_readout_ctrl_if.slave      bus,
    output readout_state_t         dbg_state,
    output logic [N_OUT*CNT_W-1:0] dbg_counts
);
    localparam int CLS_W  = cls_w(N_OUT);
    localparam int STEP_W = $clog2(T_STEPS + 1);
    localparam logic [CLS_W-1:0]  LAST_IDX  = CLS_W'(N_OUT - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);

    readout_state_t    state;
    logic [STEP_W-1:0] step_cnt;
    logic [CLS_W-1:0]  scan_idx;
    logic [CLS_W-1:0]  best_cls;
    logic [CNT_W-1:0]  best_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic              req_ready_q, start_en_q, res_valid_q, busy_q;
    logic [CLS_W-1:0]  res_class_q;
    logic [CNT_W-1:0]  res_count_q;
    logic              clr, cnt_en, take;
    logic [CLS_W-1:0]  next_cls;
    logic [CNT_W-1:0]  next_cnt;

    assign clr    = (state == IDLE) && bus.req_valid;
    assign cnt_en = (state == RUN) && bus.spk_valid;

    spike_counter_bank #(
        .N_OUT(N_OUT),
        .CNT_W(CNT_W),
        .CLS_W(CLS_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .en      (cnt_en),
        .spk     (bus.spk),
        .rd_idx  (scan_idx),
        .cnt_flat(dbg_counts),
        .rd_cnt  (rd_cnt)
    );

    // Index 0 seeds the best; later indices win only when strictly larger, so ties keep the lowest index.
    assign take     = (scan_idx == '0) || (rd_cnt > best_cnt);
    assign next_cls = take ? scan_idx : best_cls;
    assign next_cnt = take ? rd_cnt : best_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            step_cnt    <= '0;
            scan_idx    <= '0;
            best_cls    <= '0;
            best_cnt    <= '0;
            req_ready_q <= 1'b1;
            start_en_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_class_q <= '0;
            res_count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state       <= RUN;
                        step_cnt    <= '0;
                        req_ready_q <= 1'b0;
                        start_en_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.spk_valid) begin
                        step_cnt <= step_cnt + STEP_W'(1);
                        if (step_cnt == LAST_STEP) begin
                            state      <= SCAN;
                            start_en_q <= 1'b0;
                            scan_idx   <= '0;
                        end
                    end
                end
                SCAN: begin
                    best_cls <= next_cls;
                    best_cnt <= next_cnt;
                    scan_idx <= scan_idx + CLS_W'(1);
                    if (scan_idx == LAST_IDX) begin
                        state       <= RESULT;
                        busy_q      <= 1'b0;
                        res_valid_q <= 1'b1;
                        res_class_q <= next_cls;
                        res_count_q <= next_cnt;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.start_en  = start_en_q;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = busy_q;
    assign bus.res_class = res_class_q;
    assign bus.res_count = res_count_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_snn_readout_ctrl.sv
// Directed bench for snn_readout_ctrl: one 10-class/4-step/8-bit instance and
// one 10-class/20-step/4-bit instance for counter saturation.
module tb_snn_readout_ctrl;
    import snn_pkg::*;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] exp_q[$];

    snn_readout_ctrl_if #(.N_OUT(10), .CNT_W(8)) a_if();
    snn_readout_ctrl_if #(.N_OUT(10), .CNT_W(4)) b_if();
    readout_state_t a_dbg_state, b_dbg_state;
    logic [79:0]    a_dbg_counts;
    logic [39:0]    b_dbg_counts;

    snn_readout_ctrl #(.N_OUT(10), .T_STEPS(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if),
        .dbg_state(a_dbg_state), .dbg_counts(a_dbg_counts)
    );

    snn_readout_ctrl #(.N_OUT(10), .T_STEPS(20), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if),
        .dbg_state(b_dbg_state), .dbg_counts(b_dbg_counts)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic spk_step(input logic [9:0] v);
        a_if.spk_valid = 1'b1;
        a_if.spk       = v;
        tick();
        a_if.spk_valid = 1'b0;
        a_if.spk       = '0;
    endtask

    // Drives four timesteps, then waits for the result and checks it against the scoreboard.
    task automatic steps_and_result(input logic [9:0] v0, input logic [9:0] v1,
                                    input logic [9:0] v2, input logic [9:0] v3,
                                    input int gap, input bit scan_pulse);
        int lat;
        logic [31:0] exp;
        repeat (gap) tick();
        spk_step(v0);
        repeat (gap) tick();
        spk_step(v1);
        repeat (gap) tick();
        spk_step(v2);
        repeat (gap) tick();
        spk_step(v3);
        check("start_en_off_after_last_step", 32'(a_if.start_en), 32'd0);
        check("state_scan_after_last_step", 32'(a_dbg_state), 32'(SCAN));
        lat = 1;
        if (scan_pulse) begin
            spk_step(10'h3ff);
            lat = 2;
        end
        while (!a_if.res_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("res_latency", 32'(lat), 32'd11);
        exp = exp_q.pop_front();
        check("res_class", 32'(a_if.res_class), 32'(exp[31:16]));
        check("res_count", 32'(a_if.res_count), 32'(exp[15:0]));
    endtask

    task automatic run_a(input logic [9:0] v0, input logic [9:0] v1,
                         input logic [9:0] v2, input logic [9:0] v3,
                         input int gap, input bit scan_pulse);
        a_if.req_valid = 1'b1;
        tick();
        a_if.req_valid = 1'b0;
        check("start_en_after_accept", 32'(a_if.start_en), 32'd1);
        check("busy_after_accept", 32'(a_if.busy), 32'd1);
        steps_and_result(v0, v1, v2, v3, gap, scan_pulse);
    endtask

    task automatic ack_a;
        a_if.res_ready = 1'b1;
        tick();
        a_if.res_ready = 1'b0;
        check("res_valid_after_ack", 32'(a_if.res_valid), 32'd0);
        check("req_ready_after_ack", 32'(a_if.req_ready), 32'd1);
    endtask

    // Stimulus and checks
    initial begin
        int hits;
        int lat;
        reset = 1'b0;
        a_if.req_valid = 1'b0; a_if.spk_valid = 1'b0; a_if.spk = '0; a_if.res_ready = 1'b0;
        b_if.req_valid = 1'b0; b_if.spk_valid = 1'b0; b_if.spk = '0; b_if.res_ready = 1'b0;
        repeat (3) tick();

        check("rst_req_ready", 32'(a_if.req_ready), 32'd1);
        check("rst_start_en", 32'(a_if.start_en), 32'd0);
        check("rst_res_valid", 32'(a_if.res_valid), 32'd0);
        check("rst_busy", 32'(a_if.busy), 32'd0);
        check("rst_res_class", 32'(a_if.res_class), 32'd0);
        check("rst_res_count", 32'(a_if.res_count), 32'd0);
        reset = 1'b1;
        tick();
        check("req_ready_out_of_reset", 32'(a_if.req_ready), 32'd1);

        // Basic run: class 3 every step, class 7 on two steps
        exp_q.push_back({16'd3, 16'd4});
        run_a(10'h088, 10'h008, 10'h088, 10'h008, 0, 1'b0);
        check("basic_cnt7", 32'(a_dbg_counts[7*8 +: 8]), 32'd2);
        ack_a();

        // Tie between classes 2 and 5
        exp_q.push_back({16'd2, 16'd4});
        run_a(10'h024, 10'h024, 10'h024, 10'h024, 0, 1'b0);
        ack_a();

        // Gapped steps plus stray strobes in IDLE, SCAN and RESULT
        spk_step(10'h3ff);
        exp_q.push_back({16'd3, 16'd4});
        run_a(10'h088, 10'h008, 10'h088, 10'h008, 3, 1'b1);
        spk_step(10'h3ff);
        spk_step(10'h3ff);
        check("gap_class_after_result_pulse", 32'(a_if.res_class), 32'd3);
        check("gap_count_after_result_pulse", 32'(a_if.res_count), 32'd4);
        check("gap_cnt3", 32'(a_dbg_counts[3*8 +: 8]), 32'd4);
        check("gap_cnt9", 32'(a_dbg_counts[9*8 +: 8]), 32'd0);
        ack_a();

        // Backpressure with a pending request
        exp_q.push_back({16'd3, 16'd4});
        run_a(10'h088, 10'h008, 10'h088, 10'h008, 0, 1'b0);
        a_if.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("bp_res_valid", 32'(a_if.res_valid), 32'd1);
            check("bp_res_class", 32'(a_if.res_class), 32'd3);
            check("bp_res_count", 32'(a_if.res_count), 32'd4);
            check("bp_req_ready", 32'(a_if.req_ready), 32'd0);
            tick();
        end
        a_if.res_ready = 1'b1;
        tick();
        a_if.res_ready = 1'b0;
        check("bp_r1_res_valid", 32'(a_if.res_valid), 32'd0);
        check("bp_r1_req_ready", 32'(a_if.req_ready), 32'd1);
        check("bp_r1_start_en", 32'(a_if.start_en), 32'd0);
        tick();
        a_if.req_valid = 1'b0;
        check("bp_r2_start_en", 32'(a_if.start_en), 32'd1);
        check("bp_r2_req_ready", 32'(a_if.req_ready), 32'd0);
        check("bp_r2_busy", 32'(a_if.busy), 32'd1);
        exp_q.push_back({16'd2, 16'd4});
        steps_and_result(10'h024, 10'h024, 10'h024, 10'h024, 0, 1'b0);
        ack_a();
        repeat (2) tick();
        check("bp_single_run_idle", 32'(a_if.busy), 32'd0);
        check("bp_single_run_ready", 32'(a_if.req_ready), 32'd1);

        // Reset at the second timestep of a run
        a_if.req_valid = 1'b1;
        tick();
        a_if.req_valid = 1'b0;
        spk_step(10'h200);
        a_if.spk_valid = 1'b1;
        a_if.spk       = 10'h200;
        reset = 1'b0;
        tick();
        a_if.spk_valid = 1'b0;
        a_if.spk       = '0;
        reset = 1'b1;
        check("mid_reset_start_en", 32'(a_if.start_en), 32'd0);
        check("mid_reset_busy", 32'(a_if.busy), 32'd0);
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            if (a_if.res_valid) hits++;
            tick();
        end
        check("mid_reset_no_result", 32'(hits), 32'd0);
        exp_q.push_back({16'd0, 16'd0});
        run_a(10'h000, 10'h000, 10'h000, 10'h000, 0, 1'b0);
        ack_a();

        // Saturation on the 4-bit instance: 20 spikes on class 1
        b_if.req_valid = 1'b1;
        tick();
        b_if.req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            b_if.spk_valid = 1'b1;
            b_if.spk       = 10'h002;
            tick();
            b_if.spk_valid = 1'b0;
            b_if.spk       = '0;
        end
        lat = 1;
        while (!b_if.res_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("sat_latency", 32'(lat), 32'd11);
        check("sat_res_class", 32'(b_if.res_class), 32'd1);
        check("sat_res_count", 32'(b_if.res_count), 32'd15);
        b_if.res_ready = 1'b1;
        tick();
        b_if.res_ready = 1'b0;
        check("sat_res_valid_after_ack", 32'(b_if.res_valid), 32'd0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snn_readout_ctrl.md
# snn_readout_ctrl

Host-side run controller and output decoder for the `SNN` core. Accepts an inference request and drives `SNN`'s `start_en` for a fixed number of timesteps. Accumulates per-class output-spike counts from the core's output layer, then performs a sequential argmax scan and returns the winning class over a valid/ready handshake. Sits between the host/test sequencer and the `SNN` core, consuming what the core produces and producing what the core consumes.

## Interface
- `N_OUT`, 10, number of output neurons/classes (≥2)
- `T_STEPS`, 100, timesteps per inference run (≥1)
- `CNT_W`, 8, per-class spike counter width (saturating)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `req_valid`  in  1  host requests an inference run
- `req_ready`  out  1  high only in IDLE
- `start_en`  out  1  run enable to `SNN`, registered
- `spk_valid`  in  1  `SNN` finished one timestep; `spk` valid this cycle
- `spk`  in  N_OUT  output-layer spikes for that timestep
- `res_valid`  out  1  result available
- `res_ready`  in  1  host accepts result
- `res_class`  out  CLS_W = max(1,$clog2(N_OUT))  winning class index
- `res_count`  out  CNT_W  spike count of winning class
- `busy`  out  1  high in RUN or SCAN

## Operation
- States: IDLE → RUN → SCAN → RESULT → IDLE.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, all class counters and the step counter are cleared and the block enters RUN.
- RUN: `start_en`=1. Each cycle with `spk_valid`=1 increments the step counter. It also increments `cnt[i]` for every set `spk[i]`. Counters saturate at 2^CNT_W−1 and do not wrap. On the `spk_valid` that brings the step count to T_STEPS, the block goes to SCAN.
- `spk_valid` outside RUN is ignored: no counter changes.
- SCAN: one class is compared per cycle, index 0..N_OUT−1. Best is initialised from index 0. Index i replaces best only if `cnt[i] > best_cnt` (strict), so ties resolve to the lowest index. After index N_OUT−1 the block goes to RESULT.
- RESULT: `res_valid`=1, and `res_class`/`res_count` are held stable. On `res_ready`, the block returns to IDLE.
- `req_valid` is ignored outside IDLE.
- Reset (`reset`=0 at a rising edge) from any state leads to IDLE, with all counters cleared.
- Reset values: `req_ready`=1 once out of reset; `start_en`, `res_valid`, `busy` =0; `res_class`, `res_count` =0.

## Timing
- Request accepted at edge k. Then `start_en`=1, `busy`=1 from cycle k+1.
- Last timestep `spk_valid` sampled at edge t. From cycle t+1: `start_en`=0, state SCAN, scan index 0.
- Scan occupies cycles t+1..t+N_OUT. `res_valid`=1 from cycle t+N_OUT+1. Latency from last timestep to result is N_OUT+1 cycles.
- `res_valid && res_ready` at edge r gives `res_valid`=0 and `req_ready`=1 at cycle r+1.
- No back-to-back bypass: a new request is accepted no earlier than cycle r+1.
- `spk` bits are only sampled when `spk_valid`=1. Within RUN, any number of idle cycles between timesteps is allowed.
- Step counter width is $clog2(T_STEPS+1), and it compares equal to T_STEPS.
- Reset asserted mid-RUN: `start_en`=0 at the next cycle, and no result is produced.

## Structure
- Shared package `snn_pkg` holds:
  - the state enum `readout_state_t` (IDLE, RUN, SCAN, RESULT);
  - the CLS_W derivation function;
  - the saturating-increment helper function.
- Sub-module `spike_counter_bank`: N_OUT saturating CNT_W counters. It has `clr`, `en`, `spk` inputs and a flat count bus output, plus a read mux by index for the scan.
- Top level holds the FSM, step counter, scan index, and best registers.

## Test plan
- Basic run, N_OUT=10, T_STEPS=4: class 3 spikes every step, class 7 on 2 steps. Required: `res_class`=3, `res_count`=4, and `res_valid` exactly 11 cycles after the 4th `spk_valid`.
- Tie: classes 2 and 5 both spike 4 times, nothing else spikes. Required: `res_class`=2, `res_count`=4.
- Saturation, CNT_W=4, T_STEPS=20: class 1 spikes every step. Required: `res_count`=15, and no wrap to 4.
- Gapped `spk_valid` (idle cycles between steps) plus `spk_valid` pulses in IDLE and RESULT. Required: only the 4 in-RUN timesteps count, and the result equals the gap-free run.
- Backpressure: `res_ready` held low 20 cycles, with `req_valid` held high throughout. Required: `res_valid` and the outputs stay stable, `req_ready`=0, and exactly one new run starts at cycle r+1 after the handshake.
- Reset low at the 2nd timestep of RUN. Required: `start_en`=0 next cycle and `res_valid` never asserts. A fresh run then yields clean counts.
